// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU serial link: frame layout, flag/error bit
// positions, the serializer state encoding and the frame-tail builder.
package mtm_alu_pkg;

    localparam int   FRAME_BITS = 11;
    localparam logic TYPE_DATA  = 1'b0;
    localparam logic TYPE_CMD   = 1'b1;

    // Bit positions inside in_err_flags (one-hot)
    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    // Bit positions inside in_flags
    localparam int CARRY = 3;
    localparam int OVFL  = 2;
    localparam int ZERO  = 1;
    localparam int NEG   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Everything of a frame after the start bit: {type, payload[7:0], stop}.
    // Frames 0..3 of a data response carry C bytes MSB first; the last frame
    // of a data response and the only frame of an error response carry ctl.
    function automatic logic [9:0] frame_tail(input logic        err,
                                              input logic [2:0]  idx,
                                              input logic [31:0] c,
                                              input logic [7:0]  ctl);
        logic [7:0] pl;
        logic       ty;
        ty = TYPE_DATA;
        case (idx)
            3'd0:    pl = c[31:24];
            3'd1:    pl = c[23:16];
            3'd2:    pl = c[15:8];
            3'd3:    pl = c[7:0];
            default: pl = ctl;
        endcase
        if (err || (idx > 3'd3)) begin
            ty = TYPE_CMD;
            pl = ctl;
        end
        return {ty, pl, 1'b1};
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_crc3.sv
// CRC-3 (x^3 + x + 1, init 0) over a 37-bit vector, MSB first.
// Purely combinational; evaluated on the request inputs at accept time.
module mtm_alu_crc3 (
    input  logic [36:0] data,
    output logic [2:0]  crc
);

    logic fb;

    // Bit-serial LFSR unrolled over all 37 message bits
    always_comb begin
        crc = 3'b000;
        fb  = 1'b0;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ data[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Transmit end of the ALU serial link. Converts one ALU result (5 frames) or
// one error report (1 frame) into 11-bit frames {0, type, payload, 1} on sout.
// Optional macro MTM_ALU_SER_IFG_EN inserts IFG_BITS idle-high cycles between
// consecutive frames of one response; without it frames are back-to-back.
//
// state | meaning
// IDLE  | sout high, in_ready high, waiting for in_valid
// SHIFT | shifting the current frame out, bit_cnt 10 -> 0
// GAP   | idle-high gap between frames of one response
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int IFG_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_err,
    input  logic [31:0] in_c,
    input  logic [3:0]  in_flags,
    input  logic [2:0]  in_err_flags,
    output logic        sout,
    output logic        busy
);

`ifdef MTM_ALU_SER_IFG_EN
    localparam int GAP_CYCLES = IFG_BITS;
`else
    localparam int GAP_CYCLES = 0;
`endif
    localparam int GW = (IFG_BITS > 1) ? $clog2(IFG_BITS) : 1;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [2:0]  frame_cnt;
    logic [GW-1:0] gap_cnt;
    logic        err_q;
    logic [31:0] c_q;
    logic [7:0]  ctl_q;
    logic [9:0]  sr;

    logic [2:0]  crc;
    logic [2:0]  e;
    logic [7:0]  err_payload;
    logic [7:0]  data_ctl;
    logic [7:0]  ctl_new;
    logic        last_frame;
    logic [9:0]  next_tail;

    mtm_alu_crc3 u_crc3 (
        .data ({in_c, 1'b0, in_flags}),
        .crc  (crc)
    );

    assign e           = {in_err_flags[ERR_DATA], in_err_flags[ERR_CRC], in_err_flags[ERR_OP]};
    assign err_payload = {1'b1, e, e, ^{1'b1, e, e}};
    assign data_ctl    = {1'b0, in_flags[CARRY], in_flags[OVFL], in_flags[ZERO],
                          in_flags[NEG], crc};
    assign ctl_new     = in_err ? err_payload : data_ctl;

    assign last_frame  = (frame_cnt == (err_q ? 3'd0 : 3'd4));
    assign next_tail   = frame_tail(err_q, frame_cnt + 3'd1, c_q, ctl_q);

    // Serializer FSM; sout, in_ready and busy are all registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sout      <= 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            err_q     <= 1'b0;
            c_q       <= '0;
            ctl_q     <= '0;
            sr        <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        err_q     <= in_err;
                        c_q       <= in_c;
                        ctl_q     <= ctl_new;
                        sr        <= frame_tail(in_err, 3'd0, in_c, ctl_new);
                        sout      <= 1'b0;
                        bit_cnt   <= 4'(FRAME_BITS - 1);
                        frame_cnt <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != 4'd0) begin
                        sout    <= sr[9];
                        sr      <= {sr[8:0], 1'b1};
                        bit_cnt <= bit_cnt - 4'd1;
                    end else if (last_frame) begin
                        sout     <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (GAP_CYCLES != 0) begin
                        sout    <= 1'b1;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end else begin
                        sr        <= next_tail;
                        sout      <= 1'b0;
                        bit_cnt   <= 4'(FRAME_BITS - 1);
                        frame_cnt <= frame_cnt + 3'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        sr        <= next_tail;
                        sout      <= 1'b0;
                        bit_cnt   <= 4'(FRAME_BITS - 1);
                        frame_cnt <= frame_cnt + 3'd1;
                        state     <= SHIFT;
                    end
                end
                default: begin
                    sout     <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: expected frames are queued when
// a request is accepted and compared as the receiver decodes sout.
module tb_mtm_alu_serializer;

`ifdef MTM_ALU_SER_IFG_EN
    localparam int IFG = 2;
`else
    localparam int IFG = 0;
`endif
    localparam int DATA_LEN = 55 + 4 * IFG;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_err;
    logic [31:0] in_c;
    logic [3:0]  in_flags;
    logic [2:0]  in_err_flags;
    logic        sout;
    logic        busy;

    mtm_alu_serializer #(.IFG_BITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_err       (in_err),
        .in_c         (in_c),
        .in_flags     (in_flags),
        .in_err_flags (in_err_flags),
        .sout         (sout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] frame;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-3 by polynomial long division of m * x^3 by x^3+x+1
    function automatic logic [2:0] crc_ref(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic void push_frame(input logic [10:0] f, input int gap);
        exp_t x;
        x.frame = f;
        x.gap   = gap;
        exp_q.push_back(x);
    endfunction

    function automatic void push_data(input logic [31:0] c, input logic [3:0] fl, input int gap0);
        logic [31:0] cc;
        cc = c;
        for (int i = 0; i < 4; i++)
            push_frame({2'b00, cc[31 - 8 * i -: 8], 1'b1}, (i == 0) ? gap0 : IFG);
        push_frame({2'b01, 1'b0, fl, crc_ref({c, 1'b0, fl}), 1'b1}, IFG);
    endfunction

    function automatic void push_err(input logic [2:0] ef, input int gap0);
        logic [6:0] b;
        int         ones;
        b    = {1'b1, ef, ef};
        ones = 0;
        for (int i = 0; i < 7; i++) if (b[i]) ones++;
        push_frame({2'b01, b, ones[0], 1'b1}, gap0);
    endfunction

    // Receiver: decode frames from sout and score them against the queue
    int          ncnt = 0;
    int          last_stop = 0;
    int          start_gap = -1;
    int          rx_cnt = 0;
    int          frames_rx = 0;
    bit          has_stop = 0;
    bit          active = 0;
    logic [10:0] rx;
    exp_t        ex;

    always @(negedge clk) begin
        ncnt++;
        if (rst) begin
            active   = 0;
            has_stop = 0;
        end else if (active) begin
            rx = {rx[9:0], sout};
            rx_cnt++;
            if (rx_cnt == 11) begin
                active    = 0;
                frames_rx++;
                last_stop = ncnt;
                has_stop  = 1;
                chk("q_has_exp", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    ex = exp_q.pop_front();
                    chk("frame", 32'(rx), 32'(ex.frame));
                    if (ex.gap >= 0) chk("gap", 32'(start_gap), 32'(ex.gap));
                end
            end
        end else if (sout === 1'b0) begin
            active    = 1;
            rx        = 11'd0;
            rx_cnt    = 1;
            start_gap = has_stop ? (ncnt - last_stop - 1) : -1;
        end
    end

    task automatic send(input logic err, input logic [2:0] ef, input logic [31:0] c,
                        input logic [3:0] fl, input bit hold, input int gap0, input bit lit);
        int n;
        @(posedge clk); #1;
        in_valid     = 1'b1;
        in_err       = err;
        in_err_flags = ef;
        in_c         = c;
        in_flags     = fl;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 32'(n < 300), 32'd1);
        @(posedge clk);
        if (!lit) begin
            if (err) push_err(ef, gap0);
            else     push_data(c, fl, gap0);
        end
        #1;
        if (!hold) begin
            in_valid     = 1'b0;
            in_c         = $urandom;
            in_flags     = 4'($urandom);
            in_err_flags = 3'($urandom);
            in_err       = 1'($urandom);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int n;
        @(negedge clk);
        chk({tag, "_start"}, 32'(sout), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (n < 400) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr;
        rst = 1'b1; in_valid = 1'b0; in_err = 1'b0;
        in_c = '0; in_flags = '0; in_err_flags = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sout", 32'(sout), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Zero result: literal frames
        for (int i = 0; i < 4; i++) push_frame(11'b00_00000000_1, (i == 0) ? -1 : IFG);
        push_frame(11'b01_00010110_1, IFG);
        send(1'b0, 3'b000, 32'h0000_0000, 4'b0010, 1'b0, -1, 1'b1);
        wait_done("zero", DATA_LEN);

        send(1'b0, 3'b000, 32'h3333_3333, 4'b0000, 1'b0, -1, 1'b0);
        wait_done("add", DATA_LEN);

        // Error reports: literal frames
        push_frame(11'b01_11001001_1, -1);
        send(1'b1, 3'b100, 32'hDEAD_BEEF, 4'b1111, 1'b0, -1, 1'b1);
        wait_done("err_data", 11);
        push_frame(11'b01_10100101_1, -1);
        send(1'b1, 3'b010, 32'h1234_5678, 4'b0101, 1'b0, -1, 1'b1);
        wait_done("err_crc", 11);
        push_frame(11'b01_10010011_1, -1);
        send(1'b1, 3'b001, 32'hFFFF_FFFF, 4'b1010, 1'b0, -1, 1'b1);
        wait_done("err_op", 11);

        for (int k = 0; k < 3; k++) begin
            send(1'b0, 3'b000, $urandom, 4'($urandom), 1'b0, -1, 1'b0);
            wait_done("rand", DATA_LEN);
        end

        // Back-to-back with in_valid held high
        send(1'b0, 3'b000, 32'hA5C3_0F81, 4'b1001, 1'b1, -1, 1'b0);
        send(1'b1, 3'b010, 32'h0, 4'b0, 1'b0, 1, 1'b0);
        wait_done("b2b", 11);

        // Reset at bit 5 of frame 2, with in_valid asserted alongside rst
        send(1'b0, 3'b000, 32'h8844_2211, 4'b0110, 1'b0, -1, 1'b0);
        repeat (27 + 2 * IFG) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; in_err = 1'b1; in_err_flags = 3'b001;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_sout", 32'(sout), 32'd1);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        fr = frames_rx;
        repeat (15) @(negedge clk);
        chk("abort_quiet", 32'(frames_rx), 32'(fr));
        chk("abort_idle", 32'(sout), 32'd1);

        send(1'b0, 3'b000, 32'h0F0F_F0F0, 4'b1100, 1'b0, -1, 1'b0);
        wait_done("post_rst", DATA_LEN);

        repeat (5) @(negedge clk);
        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
